// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared state encoding, RGB byte-order codes and default timing.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_VSYNC = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int c_RGB_ORDER_R_LOW  = 0;
   localparam int c_RGB_ORDER_R_HIGH = 1;

   localparam int c_HDISP  = 800;
   localparam int c_VDISP  = 480;
   localparam int c_HFP    = 40;
   localparam int c_HPULSE = 48;
   localparam int c_HBP    = 40;
   localparam int c_VFP    = 13;
   localparam int c_VPULSE = 3;
   localparam int c_VBP    = 29;
   localparam int c_PIX_W  = 32;

endpackage
`default_nettype wire

// File: rtl/vga_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_stream_if
// Purpose  : FWFT pixel FIFO read port plus the FIFO-full flag.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_stream_if
   import vga_pkg::*;
#(
   parameter int PIX_W = c_PIX_W
) ();

   logic [PIX_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;
   logic             fifo_full;

   modport master (
      output pix_data,
      output pix_valid,
      output fifo_full,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      input  fifo_full,
      output pix_ready
   );

endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster counters, active flag and registered HS/VS/BLANK.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
   import vga_pkg::*;
#(
   parameter int HDISP  = c_HDISP,
   parameter int VDISP  = c_VDISP,
   parameter int HFP    = c_HFP,
   parameter int HPULSE = c_HPULSE,
   parameter int HBP    = c_HBP,
   parameter int VFP    = c_VFP,
   parameter int VPULSE = c_VPULSE,
   parameter int VBP    = c_VBP,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0
) (
   input  wire logic pixel_clk,
   input  wire logic pixel_rst,
   output logic      active,
   output logic      frame_first,
   output logic      frame_last,
   output logic      vid_hs,
   output logic      vid_vs,
   output logic      vid_blank
);

   localparam int XLEN = HDISP + HFP + HPULSE + HBP;
   localparam int YLEN = VDISP + VFP + VPULSE + VBP;
   localparam int XW   = $clog2(XLEN);
   localparam int YW   = $clog2(YLEN);

   localparam logic [XW-1:0] c_X_LAST = XW'(XLEN - 1);
   localparam logic [YW-1:0] c_Y_LAST = YW'(YLEN - 1);

   logic [XW-1:0] r_px;
   logic [YW-1:0] r_py;
   logic          w_hs_on;
   logic          w_vs_on;

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         r_px <= '0;
         r_py <= '0;
      end else if (r_px == c_X_LAST) begin
         r_px <= '0;
         r_py <= (r_py == c_Y_LAST) ? '0 : r_py + 1'b1;
      end else begin
         r_px <= r_px + 1'b1;
      end
   end

   always_comb begin
      active      = (int'(r_px) < HDISP) && (int'(r_py) < VDISP);
      frame_first = (r_px == '0) && (r_py == '0);
      frame_last  = (r_px == c_X_LAST) && (r_py == c_Y_LAST);
      w_hs_on     = (int'(r_px) >= HDISP + HFP) && (int'(r_px) < HDISP + HFP + HPULSE);
      w_vs_on     = (int'(r_py) >= VDISP + VFP) && (int'(r_py) < VDISP + VFP + VPULSE);
   end

   // Outputs describe the counter position of the previous cycle
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         vid_hs    <= ~HS_POL;
         vid_vs    <= ~VS_POL;
         vid_blank <= 1'b0;
      end else begin
         vid_hs    <= w_hs_on ? HS_POL : ~HS_POL;
         vid_vs    <= w_vs_on ? VS_POL : ~VS_POL;
         vid_blank <= active;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_stream.sv
`default_nettype none
// ============================================================================
// Module   : vga_stream
// Purpose  : VGA output stage pulling pixels from an FWFT FIFO, frame-locked.
// Revision : 1.0 - initial release
// ============================================================================
module vga_stream
   import vga_pkg::*;
#(
   parameter int HDISP               = c_HDISP,
   parameter int VDISP               = c_VDISP,
   parameter int HFP                 = c_HFP,
   parameter int HPULSE              = c_HPULSE,
   parameter int HBP                 = c_HBP,
   parameter int VFP                 = c_VFP,
   parameter int VPULSE              = c_VPULSE,
   parameter int VBP                 = c_VBP,
   parameter bit HS_POL              = 1'b0,
   parameter bit VS_POL              = 1'b0,
   parameter int PIX_W               = c_PIX_W,
   parameter int RGB_ORDER           = c_RGB_ORDER_R_LOW,
   parameter bit RESYNC_ON_UNDERFLOW = 1'b1
) (
   input  wire logic   pixel_clk,
   input  wire logic   pixel_rst,
   vga_stream_if.slave pix,
   output logic        vid_clk,
   output logic        vid_hs,
   output logic        vid_vs,
   output logic        vid_blank,
   output logic [23:0] vid_rgb,
   output logic        frame_start,
   output logic        underflow,
   output logic [15:0] underflow_cnt,
   output logic        running
);

   logic        w_active;
   logic        w_frame_first;
   logic        w_frame_last;
   logic        r_full_meta;
   logic        r_full_s;
   state_t      r_state;
   state_t      w_state_next;
   logic        w_run;
   logic        w_pop_ok;
   logic        w_underflow;
   logic [23:0] w_rgb_mapped;

   assign vid_clk = pixel_clk;

   vga_timing #(
      .HDISP  (HDISP),
      .VDISP  (VDISP),
      .HFP    (HFP),
      .HPULSE (HPULSE),
      .HBP    (HBP),
      .VFP    (VFP),
      .VPULSE (VPULSE),
      .VBP    (VBP),
      .HS_POL (HS_POL),
      .VS_POL (VS_POL)
   ) u_timing (
      .pixel_clk   (pixel_clk),
      .pixel_rst   (pixel_rst),
      .active      (w_active),
      .frame_first (w_frame_first),
      .frame_last  (w_frame_last),
      .vid_hs      (vid_hs),
      .vid_vs      (vid_vs),
      .vid_blank   (vid_blank)
   );

   // fifo_full comes from the write clock domain
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         r_full_meta <= 1'b0;
         r_full_s    <= 1'b0;
      end else begin
         r_full_meta <= pix.fifo_full;
         r_full_s    <= r_full_meta;
      end
   end

   if (RGB_ORDER == c_RGB_ORDER_R_HIGH) begin : g_order_r_high
      assign w_rgb_mapped = pix.pix_data[23:0];
   end else begin : g_order_r_low
      assign w_rgb_mapped = {pix.pix_data[7:0], pix.pix_data[15:8], pix.pix_data[23:16]};
   end

   if (PIX_W > 24) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^pix.pix_data[PIX_W-1:24];
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_FILL:  if (r_full_s)     w_state_next = ST_VSYNC;
         ST_VSYNC: if (w_frame_last) w_state_next = ST_RUN;
         ST_RUN:   if (w_underflow && RESYNC_ON_UNDERFLOW) w_state_next = ST_FILL;
         default:  w_state_next = ST_FILL;
      endcase
   end

   always_comb begin
      w_run         = (r_state == ST_RUN);
      running       = w_run;
      pix.pix_ready = w_run && w_active;
      w_pop_ok      = w_run && w_active && pix.pix_valid;
      w_underflow   = w_run && w_active && !pix.pix_valid;
   end

   // Pixel path registers line up with vid_blank from the timing block
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         vid_rgb       <= '0;
         frame_start   <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         vid_rgb     <= w_pop_ok ? w_rgb_mapped : 24'h0;
         frame_start <= w_run && w_frame_first;
         underflow   <= w_underflow;
         if (w_underflow && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire
